switching_median_restorer: RTL
==============================

# switching_median_restorer

Restoration stage of the switching median filter. It accepts one 3x3 window of 8-bit pixels together with the nine per-pixel noise flags produced by the noise detector stage, and emits one restored centre pixel. If the centre pixel is clean, it passes through unchanged. If the centre pixel is flagged, the block replaces it with the median of the unflagged neighbours, computed by a multi-cycle odd-even transposition sort. Valid/ready handshakes on both sides let it sit between the window/detector stage and the output pixel writer.

## Interface

Parameters:
- DATA_W, 8, pixel width.
- WIN, 9, window size; fixed at 9, not user-tunable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window and flags present.
- in_ready  out  1  block can accept a window; high only in IDLE.
- X0..X8  in  DATA_W each  window pixels; X4 is the centre.
- F0..F8  in  1 each  noise flags from the detector; 1 = noisy.
- out_valid  out  1  restored pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- Y  out  DATA_W  restored centre pixel.
- Y_fixed  out  1  1 = Y was substituted; 0 = X4 passed through.

## Operation

- FSM states: IDLE, SORT, SELECT, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready the window is captured into s[0..8].
  - Flagged positions are loaded as the sentinel {DATA_W{1'b1}}.
  - Unflagged count N (0..9) is latched.
- Capture routing:
  - F4=0: Y<=X4, Y_fixed<=0, go to HOLD.
  - F4=1 and N=0: Y<=last_y, Y_fixed<=1, go to HOLD.
  - Otherwise: go to SORT with pass counter=0.
- SORT: one odd-even transposition pass per cycle, ascending.
  - Even passes compare-exchange pairs (0,1)(2,3)(4,5)(6,7).
  - Odd passes compare-exchange pairs (1,2)(3,4)(5,6)(7,8).
  - Exactly 9 passes, then go to SELECT.
  - Sentinels sort to the top. Ties with a real 255 are harmless, because s[0..N-1] always equals the sorted unflagged set.
- SELECT:
  - N odd: Y<=s[(N-1)/2].
  - N even: Y<=(s[N/2-1]+s[N/2])>>1, with a DATA_W+1-bit sum, floor division, no overflow.
  - Y_fixed<=1, then go to HOLD.
- HOLD: out_valid=1. Y and Y_fixed stay stable until out_ready.
  - On out_valid&&out_ready: last_y<=Y, out_valid drops, go to IDLE.
- last_y: the most recently delivered Y, used only as the N=0 fallback.

## Timing

- Reset values: out_valid=0, Y=0, Y_fixed=0, last_y=0, state=IDLE. After rst_n rises, in_ready=1 combinationally from IDLE.
- Cycle 0 is the acceptance edge.
- Latency (acceptance edge to out_valid high):
  - Clean centre, or N=0: out_valid high after edge 0, i.e. 1 cycle.
  - Flagged centre, N>=1: SORT on edges 1..9, SELECT on edge 10, out_valid high after edge 10, i.e. 11 cycles.
- Throughput:
  - Clean pixel: one per 2 cycles, since in_ready returns the cycle after the handshake.
  - Flagged pixel: one per 12 cycles.
- No pipelining or overlap: in_ready=0 in SORT, SELECT and HOLD. in_valid in those states is ignored and must stay asserted upstream.
- Backpressure: out_ready low holds HOLD indefinitely with Y unchanged.
- Reset mid-operation: rst_n low at any time forces the reset values immediately. A window in progress is discarded with no output.
- X*/F* are sampled only on the acceptance edge. Later changes have no effect.

## Structure

- Package smf_pkg:
  - DATA_W and WIN constants.
  - SORT_PASSES=9.
  - Sentinel constant.
  - State enum {IDLE, SORT, SELECT, HOLD}.
  - Pixel typedef.
- One sub-module, smf_cmp_swap: a combinational two-input compare-exchange with outputs lo and hi. Instantiate it 4 times and mux the pairs by pass parity.
- N is computed with a popcount of ~F at capture.
- The pass counter is 4 bits.

## Test plan

- Clean centre: X=10,20,30,40,50,60,70,80,90, all F=0 -> Y=50, Y_fixed=0, out_valid 1 cycle after accept.
- Pepper centre, 8 clean neighbours: X4=0, F4=1, others 10,20,30,40,60,70,80,90 clean -> N=8, Y=(40+60)>>1=50, Y_fixed=1, out_valid 11 cycles after accept.
- Odd N with duplicates and a real 255: flags set on X0 and X4, X={0,5,255,255,3,0,7,255,1} with X0 flagged and X4=3 flagged -> N=7, sorted {0,1,5,7,255,255,255}, Y=7.
- All flagged: first deliver Y=50 from the clean-centre case, then send all F=1 -> Y=50 (last_y), Y_fixed=1, latency 1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> Y stable, in_ready=0, in_valid ignored; raise out_ready -> one transfer, in_ready=1 next cycle.
- Reset mid-sort: assert rst_n=0 at cycle 5 of a flagged window -> out_valid=0 and Y=0 immediately, no output emitted; after release, a clean window completes normally.

Source files
------------

// File: rtl/switching_median_restorer_pkg.sv
// Shared constants, types and helpers for the switching median restorer.
// Pixels flagged as noisy are loaded as SENTINEL so that they sort to the top.
package smf_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned WIN         = 9;
    localparam int unsigned SORT_PASSES = 9;

    typedef logic [DATA_W-1:0] pixel_t;

    localparam pixel_t SENTINEL = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SORT   = 2'd1,
        SELECT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Number of set bits in a window-wide flag vector (0..9).
    function automatic logic [3:0] popcount_win(input logic [WIN-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIN; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/switching_median_restorer_if.sv
// Upstream window/flag handshake and downstream pixel handshake of the restorer.
// master = the environment around the block, slave = the restorer itself.
interface switching_median_restorer_if #(
    parameter int unsigned DATA_W = smf_pkg::DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] X0, X1, X2, X3, X4, X5, X6, X7, X8;
    logic              F0, F1, F2, F3, F4, F5, F6, F7, F8;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Y;
    logic              Y_fixed;

    modport master (
        output in_valid, X0, X1, X2, X3, X4, X5, X6, X7, X8,
               F0, F1, F2, F3, F4, F5, F6, F7, F8, out_ready,
        input  in_ready, out_valid, Y, Y_fixed
    );

    modport slave (
        input  in_valid, X0, X1, X2, X3, X4, X5, X6, X7, X8,
               F0, F1, F2, F3, F4, F5, F6, F7, F8, out_ready,
        output in_ready, out_valid, Y, Y_fixed
    );
endinterface

// File: rtl/switching_median_restorer_cmp_swap.sv
// Combinational compare-exchange: lo gets the smaller input, hi the larger.
module smf_cmp_swap #(
    parameter int unsigned DATA_W = smf_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    always_comb begin
        if (a <= b) begin
            lo = a;
            hi = b;
        end else begin
            lo = b;
            hi = a;
        end
    end

endmodule

// File: rtl/switching_median_restorer.sv
// Restores a flagged centre pixel with the median of its unflagged neighbours
// (odd-even transposition sort, one pass per cycle); clean centres pass through.
module switching_median_restorer
    import smf_pkg::*;
#(
    parameter int unsigned DATA_W = smf_pkg::DATA_W,
    parameter int unsigned WIN    = smf_pkg::WIN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    switching_median_restorer_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] s_q [WIN];
    logic [DATA_W-1:0] s_d [WIN];
    logic [3:0]        n_q, n_d;
    logic [3:0]        pass_q, pass_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              y_fixed_q, y_fixed_d;
    logic [DATA_W-1:0] last_y_q, last_y_d;

    logic [DATA_W-1:0] x_in [WIN];
    logic [WIN-1:0]    f_in;

    logic [DATA_W-1:0] cmp_a  [4];
    logic [DATA_W-1:0] cmp_b  [4];
    logic [DATA_W-1:0] cmp_lo [4];
    logic [DATA_W-1:0] cmp_hi [4];

    logic [3:0]        mid_idx;
    logic [3:0]        mid_m1_idx;
    logic [DATA_W:0]   pair_sum;

    assign x_in = '{bus.X0, bus.X1, bus.X2, bus.X3, bus.X4,
                    bus.X5, bus.X6, bus.X7, bus.X8};
    assign f_in = {bus.F8, bus.F7, bus.F6, bus.F5, bus.F4,
                   bus.F3, bus.F2, bus.F1, bus.F0};

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.Y         = y_q;
    assign bus.Y_fixed   = y_fixed_q;

    // Even passes pair (2k,2k+1); odd passes shift the pairing up by one.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (pass_q[0]) begin
                cmp_a[k] = s_q[2*k+1];
                cmp_b[k] = s_q[2*k+2];
            end else begin
                cmp_a[k] = s_q[2*k];
                cmp_b[k] = s_q[2*k+1];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cmp
        smf_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
            .a  (cmp_a[g]),
            .b  (cmp_b[g]),
            .lo (cmp_lo[g]),
            .hi (cmp_hi[g])
        );
    end

    always_comb begin
        mid_idx    = n_q >> 1;
        mid_m1_idx = mid_idx - 4'd1;
        pair_sum   = {1'b0, s_q[mid_m1_idx]} + {1'b0, s_q[mid_idx]};
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        pass_d    = pass_q;
        y_d       = y_q;
        y_fixed_d = y_fixed_q;
        last_y_d  = last_y_q;
        for (int unsigned i = 0; i < WIN; i++) begin
            s_d[i] = s_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int unsigned i = 0; i < WIN; i++) begin
                        s_d[i] = f_in[i] ? SENTINEL : x_in[i];
                    end
                    n_d = popcount_win(~f_in);
                    if (!f_in[4]) begin
                        y_d       = x_in[4];
                        y_fixed_d = 1'b0;
                        state_d   = HOLD;
                    end else if (n_d == 4'd0) begin
                        y_d       = last_y_q;
                        y_fixed_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        pass_d  = '0;
                        state_d = SORT;
                    end
                end
            end

            SORT: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (pass_q[0]) begin
                        s_d[2*k+1] = cmp_lo[k];
                        s_d[2*k+2] = cmp_hi[k];
                    end else begin
                        s_d[2*k]   = cmp_lo[k];
                        s_d[2*k+1] = cmp_hi[k];
                    end
                end
                pass_d = pass_q + 4'd1;
                if (pass_q == 4'(SORT_PASSES - 1)) begin
                    state_d = SELECT;
                end
            end

            SELECT: begin
                // s[0..N-1] holds the sorted clean pixels; sentinels sit above.
                if (n_q[0]) begin
                    y_d = s_q[mid_idx];
                end else begin
                    y_d = pair_sum[DATA_W:1];
                end
                y_fixed_d = 1'b1;
                state_d   = HOLD;
            end

            HOLD: begin
                if (bus.out_ready) begin
                    last_y_d = y_q;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            pass_q    <= '0;
            y_q       <= '0;
            y_fixed_q <= 1'b0;
            last_y_q  <= '0;
            for (int unsigned i = 0; i < WIN; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            pass_q    <= pass_d;
            y_q       <= y_d;
            y_fixed_q <= y_fixed_d;
            last_y_q  <= last_y_d;
            for (int unsigned i = 0; i < WIN; i++) begin
                s_q[i] <= s_d[i];
            end
        end
    end

endmodule
